// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch squashes and
// data-memory wait freezes, with saturating performance counters.
module hazard_stall_unit #(
  parameter int unsigned BRANCH_PENALTY = 2,  // total IF/ID flush cycles per taken branch (1..7)
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_use_rs1,
  input  logic             IFID_use_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             pipe_freeze,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2,
    StIllegal = 2'd3
  } hz_state_e;

  // FLUSH cycles remaining after the branch cycle itself.
  localparam logic [2:0] FcntReload = 3'(BRANCH_PENALTY - 1);
  localparam bit         MultiFlush = (BRANCH_PENALTY > 1);

  hz_state_e        state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;

  assign load_use = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                    ((IFID_use_rs1 && (IDEX_rd == IFID_rs1)) ||
                     (IFID_use_rs2 && (IDEX_rd == IFID_rs2)));

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Next-state, counter updates and pipeline controls, priority busy > branch > load-use.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    pipe_freeze = 1'b0;
    hz_state    = state_q;

    if (dmem_busy) begin
      // Freeze everything; a branch pulse now is re-raised after release.
      pipe_freeze = 1'b1;
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      state_d     = StMemWait;
    end else begin
      case (state_q)
        StRun, StMemWait: begin
          state_d = StRun;
          if (branch_taken) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            if (MultiFlush) begin
              state_d = StFlush;
              fcnt_d  = FcntReload;
            end
          end else if (load_use) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
        StFlush: begin
          // ID instruction is squashed, so load-use is irrelevant here.
          IFID_flush = 1'b1;
          if (branch_taken) begin
            IDEX_flush = 1'b1;
            fcnt_d     = FcntReload;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            state_d    = MultiFlush ? StFlush : StRun;
          end else begin
            fcnt_d  = fcnt_q - 3'd1;
            state_d = (fcnt_q <= 3'd1) ? StRun : StFlush;
          end
        end
        default: state_d = StRun;
      endcase
    end

    if (reset) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      pipe_freeze = 1'b0;
      hz_state    = 2'd0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit with BRANCH_PENALTY=2, CNT_W=2.
module tb_hazard_stall_unit;

  logic       clk;
  logic       reset;
  logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
  logic       IFID_use_rs1, IFID_use_rs2, IDEX_MemRead, branch_taken, dmem_busy;
  logic       PC_write, IFID_write, IFID_flush, IDEX_flush, pipe_freeze;
  logic [1:0] hz_state, stall_cnt, flush_cnt;

  hazard_stall_unit #(
    .BRANCH_PENALTY(2),
    .CNT_W         (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .IFID_rs1    (IFID_rs1),
    .IFID_rs2    (IFID_rs2),
    .IFID_use_rs1(IFID_use_rs1),
    .IFID_use_rs2(IFID_use_rs2),
    .IDEX_rd     (IDEX_rd),
    .IDEX_MemRead(IDEX_MemRead),
    .branch_taken(branch_taken),
    .dmem_busy   (dmem_busy),
    .PC_write    (PC_write),
    .IFID_write  (IFID_write),
    .IFID_flush  (IFID_flush),
    .IDEX_flush  (IDEX_flush),
    .pipe_freeze (pipe_freeze),
    .hz_state    (hz_state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected: {PC_write, IFID_write, IFID_flush, IDEX_flush, pipe_freeze}, state, counters.
  typedef struct packed {
    logic [4:0] ctl;
    logic [1:0] st;
    logic [1:0] sc;
    logic [1:0] fc;
  } exp_t;

  localparam logic [4:0] CDef = 5'b11000;
  localparam logic [4:0] CStl = 5'b00010;
  localparam logic [4:0] CBr  = 5'b11110;
  localparam logic [4:0] CFl  = 5'b11100;
  localparam logic [4:0] CFrz = 5'b00001;
  localparam logic [4:0] CRst = 5'b00110;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the edge and queue its expectation.
  task automatic step(input string tag, input logic rst, input logic busy, input logic bt,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] ctl, input logic [1:0] st, input logic [1:0] sc,
                      input logic [1:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    dmem_busy    = busy;
    branch_taken = bt;
    IDEX_MemRead = mr;
    IDEX_rd      = rd;
    IFID_rs1     = rs1;
    IFID_use_rs1 = u1;
    IFID_rs2     = rs2;
    IFID_use_rs2 = u2;
    e.ctl = ctl;
    e.st  = st;
    e.sc  = sc;
    e.fc  = fc;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Compare combinational outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".ctl"}, 32'({PC_write, IFID_write, IFID_flush, IDEX_flush, pipe_freeze}),
            32'(e.ctl));
      check({t, ".st"}, 32'(hz_state), 32'(e.st));
      check({t, ".sc"}, 32'(stall_cnt), 32'(e.sc));
      check({t, ".fc"}, 32'(flush_cnt), 32'(e.fc));
    end
  end

  initial begin
    reset = 1'b1; dmem_busy = 1'b0; branch_taken = 1'b0; IDEX_MemRead = 1'b0;
    IDEX_rd = 5'd0; IFID_rs1 = 5'd0; IFID_rs2 = 5'd0; IFID_use_rs1 = 1'b0; IFID_use_rs2 = 1'b0;

    //   tag          rst busy bt mr rd    rs1  u1 rs2  u2  ctl   st  sc fc
    step("rst",        1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CRst, 0, 0, 0);
    step("idle",       0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CDef, 0, 0, 0);
    step("lu_rs1",     0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, CStl, 0, 0, 0);
    step("lu_after",   0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd0, 0, CDef, 0, 1, 0);
    step("ld_x0",      0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, CDef, 0, 1, 0);
    step("rs2_unused", 0, 0, 0, 1, 5'd7, 5'd1, 0, 5'd7, 0, CDef, 0, 1, 0);
    step("br",         0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, CBr,  0, 1, 0);
    step("br_flush",   0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CFl,  2, 1, 1);
    step("br_done",    0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CDef, 0, 1, 1);
    step("br_and_lu",  0, 0, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0, CBr,  0, 1, 1);
    step("flush_lu",   0, 0, 0, 1, 5'd3, 5'd3, 1, 5'd0, 0, CFl,  2, 1, 2);
    step("run2",       0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CDef, 0, 1, 2);
    step("busy_br",    0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, CFrz, 0, 1, 2);
    step("busy2",      0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CFrz, 1, 1, 2);
    step("busy3",      0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CFrz, 1, 1, 2);
    step("rel_lu",     0, 0, 0, 1, 5'd9, 5'd0, 0, 5'd9, 1, CStl, 1, 1, 2);
    step("rel_after",  0, 0, 0, 0, 5'd9, 5'd0, 0, 5'd9, 1, CDef, 0, 2, 2);
    step("busy_lu",    0, 1, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0, CFrz, 0, 2, 2);
    step("busy_lu_rel",0, 0, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0, CStl, 1, 2, 2);
    step("run3",       0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CDef, 0, 3, 2);
    step("lu_sat4",    0, 0, 0, 1, 5'd6, 5'd6, 1, 5'd0, 0, CStl, 0, 3, 2);
    step("lu_sat5",    0, 0, 0, 1, 5'd6, 5'd0, 0, 5'd6, 1, CStl, 0, 3, 2);
    step("sat_check",  0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CDef, 0, 3, 2);
    step("br_a",       0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, CBr,  0, 3, 2);
    step("br_restart", 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, CBr,  2, 3, 3);
    step("restart_fl", 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CFl,  2, 3, 3);
    step("restart_end",0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CDef, 0, 3, 3);
    step("br_sat",     0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, CBr,  0, 3, 3);
    step("rst_in_fl",  1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CRst, 0, 3, 3);
    step("post_rst",   0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CDef, 0, 0, 0);
    step("post_rst_lu",0, 0, 0, 1, 5'd2, 5'd0, 0, 5'd2, 1, CStl, 0, 0, 0);
    step("final",      0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, CDef, 0, 1, 0);

    // Let the last expectation drain, bounded in cycles.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      check("drain", 32'(sb_q.size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
